// File: rtl/digit_scan_if.sv
// digit_scan_if: display scan bus between a scan driver (master) and a
// receiver that reads the displayed value back (slave).
//   anode_in    : active-low one-hot digit select, bit k low selects digit k
//   digit_in    : digit bus, [3:0] nibble, [6:4] must be zero
//   value_out   : last complete frame {d3,d2,d1,d0}
//   value_valid : one-cycle pulse when value_out updates
//   seq_err     : one-cycle pulse on an anode order violation
//   fmt_err     : one-cycle pulse on a sampled digit with [6:4] != 0
//   stale       : level, link timed out, cleared by the next value_valid
`timescale 1ns/1ps
interface digit_scan_if;
    logic [3:0]  anode_in;
    logic [6:0]  digit_in;
    logic [15:0] value_out;
    logic        value_valid;
    logic        seq_err;
    logic        fmt_err;
    logic        stale;

    modport master (
        output anode_in, digit_in,
        input  value_out, value_valid, seq_err, fmt_err, stale
    );

    modport slave (
        input  anode_in, digit_in,
        output value_out, value_valid, seq_err, fmt_err, stale
    );
endinterface

// File: rtl/digit_scan_receiver.sv
// digit_scan_receiver: reconstructs the 16-bit hex value carried on a
// time-multiplexed four-digit display bus. Each digit is sampled once per
// dwell after the anode has been stable for SETTLE cycles, the scan order
// 0,3,2,1 is checked, and every complete frame is published with a
// one-cycle valid pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : digit_scan_if.slave (anode_in/digit_in in, results out)
// Parameters:
//   SETTLE  : stable-anode cycles before the digit bus is sampled (>= 2)
//   TIMEOUT : cycles without an anode change, while capturing, before stale
`timescale 1ns/1ps
module digit_scan_receiver #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    digit_scan_if.slave  bus
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    // The settle counter saturates one above the strobe value so the
    // strobe fires exactly once per dwell.
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
    localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT - 1);

    localparam logic [3:0] ANODE_D0 = 4'b1110;
    localparam logic [3:0] ANODE_D1 = 4'b1101;

    typedef enum logic {
        SYNC,
        CAPTURE
    } state_t;

    state_t          state_reg;
    logic [3:0]      anode_reg;
    logic [3:0]      anode_prev_reg;
    logic [6:0]      digit_reg;
    logic [SW-1:0]   settle_cnt_reg;
    logic [TW-1:0]   idle_cnt_reg;
    logic [3:0]      expect_reg;
    logic [15:0]     shadow_reg;
    logic [15:0]     value_reg;
    logic            value_valid_reg;
    logic            seq_err_reg;
    logic            fmt_err_reg;
    logic            stale_reg;

    logic            anode_change;
    logic            sample_strobe;
    logic            fmt_bad;
    logic [3:0]      anode_rot;
    logic [3:0]      slot_sel;
    logic [15:0]     shadow_ins;

    assign anode_change  = (anode_reg != anode_prev_reg);
    assign sample_strobe = !anode_change && (settle_cnt_reg == SETTLE_LAST);
    assign fmt_bad       = (digit_reg[6:4] != 3'b000);
    // The transmitter rotates right, so the next expected anode is the
    // current one rotated right.
    assign anode_rot     = {anode_reg[0], anode_reg[3:1]};

    // Shadow frame with the current nibble merged into the slot selected
    // by the registered anode. A non-one-hot anode selects no slot.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_sel[gi] = (anode_reg == ~(4'b0001 << gi));
            assign shadow_ins[gi*4 +: 4] = slot_sel[gi] ? digit_reg[3:0]
                                                        : shadow_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= SYNC;
            anode_reg       <= 4'hF;
            anode_prev_reg  <= 4'hF;
            digit_reg       <= '0;
            settle_cnt_reg  <= '0;
            idle_cnt_reg    <= '0;
            expect_reg      <= ANODE_D0;
            shadow_reg      <= '0;
            value_reg       <= '0;
            value_valid_reg <= 1'b0;
            seq_err_reg     <= 1'b0;
            fmt_err_reg     <= 1'b0;
            stale_reg       <= 1'b0;
        end else begin
            anode_reg      <= bus.anode_in;
            anode_prev_reg <= anode_reg;
            digit_reg      <= bus.digit_in;

            if (anode_change) begin
                settle_cnt_reg <= '0;
            end else if (settle_cnt_reg != SETTLE_MAX) begin
                settle_cnt_reg <= settle_cnt_reg + SW'(1);
            end

            value_valid_reg <= 1'b0;
            seq_err_reg     <= 1'b0;
            fmt_err_reg     <= 1'b0;

            case (state_reg)
                SYNC: begin
                    idle_cnt_reg <= '0;
                    if (sample_strobe && (anode_reg == ANODE_D0)) begin
                        if (fmt_bad) begin
                            fmt_err_reg <= 1'b1;
                        end else begin
                            // Stale slots from a discarded frame are all
                            // rewritten before the next publish.
                            shadow_reg <= shadow_ins;
                            expect_reg <= anode_rot;
                            state_reg  <= CAPTURE;
                        end
                    end
                end

                CAPTURE: begin
                    if (anode_change) begin
                        // An anode change outranks a coincident timeout.
                        idle_cnt_reg <= '0;
                        if (anode_reg != expect_reg) begin
                            seq_err_reg <= 1'b1;
                            state_reg   <= SYNC;
                        end
                    end else if (idle_cnt_reg == IDLE_LAST) begin
                        stale_reg    <= 1'b1;
                        idle_cnt_reg <= '0;
                        state_reg    <= SYNC;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + TW'(1);
                        if (sample_strobe) begin
                            if (fmt_bad) begin
                                fmt_err_reg <= 1'b1;
                                state_reg   <= SYNC;
                            end else begin
                                shadow_reg <= shadow_ins;
                                expect_reg <= anode_rot;
                                // d1 is the last digit of the frame; stay in
                                // CAPTURE so back-to-back frames need no resync.
                                if (anode_reg == ANODE_D1) begin
                                    value_reg       <= shadow_ins;
                                    value_valid_reg <= 1'b1;
                                    stale_reg       <= 1'b0;
                                end
                            end
                        end
                    end
                end

                default: state_reg <= SYNC;
            endcase
        end
    end

    assign bus.value_out   = value_reg;
    assign bus.value_valid = value_valid_reg;
    assign bus.seq_err     = seq_err_reg;
    assign bus.fmt_err     = fmt_err_reg;
    assign bus.stale       = stale_reg;

endmodule

// File: tb/tb_digit_scan_receiver.sv
`timescale 1ns/1ps
module tb_digit_scan_receiver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    digit_scan_if bus ();

    digit_scan_receiver #(
        .SETTLE  (4),
        .TIMEOUT (4096)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] value;
        int          dwell;
        logic [15:0] exp_value;
        int          exp_valid;
        int          exp_seq;
    } frame_vec_t;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int seq_cnt = 0;
    int fmt_cnt = 0;
    int hold_bad = 0;
    int pulse_bad = 0;
    longint cyc = 0;
    longint last_valid_cyc = 0;
    longint prev_valid_cyc = 0;
    logic [15:0] prev_val = '0;
    logic prev_vv = 1'b0;
    logic prev_se = 1'b0;
    logic prev_fe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and hold monitor, sampled 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            if (bus.value_valid === 1'b1) begin
                valid_cnt++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            if (bus.seq_err === 1'b1) seq_cnt++;
            if (bus.fmt_err === 1'b1) fmt_cnt++;
            if (bus.value_out !== prev_val && bus.value_valid !== 1'b1) hold_bad++;
            if ((bus.value_valid === 1'b1 && prev_vv) ||
                (bus.seq_err === 1'b1 && prev_se) ||
                (bus.fmt_err === 1'b1 && prev_fe)) pulse_bad++;
        end
        prev_val = bus.value_out;
        prev_vv  = (bus.value_valid === 1'b1);
        prev_se  = (bus.seq_err === 1'b1);
        prev_fe  = (bus.fmt_err === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Called at a falling edge; holds the anode/digit for n cycles.
    task automatic drive_dwell(input logic [3:0] a, input logic [6:0] d, input int n);
        bus.anode_in = a;
        bus.digit_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [15:0] v, input int n);
        drive_dwell(4'b1110, {3'b000, v[3:0]},   n);
        drive_dwell(4'b0111, {3'b000, v[15:12]}, n);
        drive_dwell(4'b1011, {3'b000, v[11:8]},  n);
        drive_dwell(4'b1101, {3'b000, v[7:4]},   n);
    endtask

    frame_vec_t vecs [5];
    int v0, s0, f0;

    initial begin
        vecs[0] = '{value: 16'hBEEF, dwell: 8,  exp_value: 16'hBEEF, exp_valid: 1, exp_seq: 0};
        vecs[1] = '{value: 16'h0000, dwell: 7,  exp_value: 16'h0000, exp_valid: 1, exp_seq: 0};
        vecs[2] = '{value: 16'hFFFF, dwell: 12, exp_value: 16'hFFFF, exp_valid: 1, exp_seq: 0};
        // Dwells shorter than SETTLE: no samples, and 0111 arrives while
        // 1110 is still expected, so the order check trips.
        vecs[3] = '{value: 16'h4321, dwell: 3,  exp_value: 16'hFFFF, exp_valid: 0, exp_seq: 1};
        vecs[4] = '{value: 16'h9A7C, dwell: 9,  exp_value: 16'h9A7C, exp_valid: 1, exp_seq: 0};

        // Reset with random inputs.
        rst_n = 1'b0;
        bus.anode_in = 4'hF;
        bus.digit_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.anode_in = 4'($urandom);
            bus.digit_in = 7'($urandom);
        end
        check("rst_value_out",   32'(bus.value_out),   32'h0);
        check("rst_value_valid", 32'(bus.value_valid), 32'h0);
        check("rst_seq_err",     32'(bus.seq_err),     32'h0);
        check("rst_fmt_err",     32'(bus.fmt_err),     32'h0);
        check("rst_stale",       32'(bus.stale),       32'h0);
        rst_n = 1'b1;
        bus.anode_in = 4'hF;
        bus.digit_in = '0;
        repeat (2) @(negedge clk);

        // Mid-frame start: 1011 and 1101 are ignored until a 1110 dwell.
        drive_dwell(4'b1011, 7'h02, 8);
        drive_dwell(4'b1101, 7'h03, 8);
        check("midstart_no_valid", 32'(valid_cnt), 32'd0);
        check("midstart_no_seq",   32'(seq_cnt),   32'd0);

        // First full frame, with the d1 sample latency checked cycle by cycle.
        drive_dwell(4'b1110, 7'h04, 8);
        drive_dwell(4'b0111, 7'h01, 8);
        drive_dwell(4'b1011, 7'h02, 8);
        bus.anode_in = 4'b1101;
        bus.digit_in = 7'h03;
        repeat (5) @(negedge clk);
        check("lat_not_yet", 32'(bus.value_valid), 32'h0);
        @(negedge clk);
        check("lat_valid",   32'(bus.value_valid), 32'h1);
        check("lat_value",   32'(bus.value_out),   32'h1234);
        repeat (2) @(negedge clk);

        // Table of back-to-back frames.
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            s0 = seq_cnt;
            drive_frame(vecs[i].value, vecs[i].dwell);
            check($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_seq", i),   32'(seq_cnt - s0),   32'(vecs[i].exp_seq));
            check($sformatf("vec%0d_value", i), 32'(bus.value_out),  32'(vecs[i].exp_value));
        end

        // Nominal 1024-cycle dwells: frames publish exactly 4096 cycles apart.
        v0 = valid_cnt;
        drive_frame(16'h1234, 1024);
        check("nom1_value", 32'(bus.value_out), 32'h1234);
        drive_frame(16'h1234, 1024);
        check("nom2_period", 32'(last_valid_cyc - prev_valid_cyc), 32'd4096);
        drive_frame(16'hBEEF, 1024);
        check("nom3_period", 32'(last_valid_cyc - prev_valid_cyc), 32'd4096);
        check("nom3_value",  32'(bus.value_out), 32'hBEEF);
        check("nom_valids",  32'(valid_cnt - v0), 32'd3);
        check("nom_stale",   32'(bus.stale), 32'h0);

        // Order violation: 1110 then 1101.
        v0 = valid_cnt;
        s0 = seq_cnt;
        drive_dwell(4'b1110, 7'h07, 8);
        drive_dwell(4'b1101, 7'h08, 8);
        check("order_seq",   32'(seq_cnt - s0),   32'd1);
        check("order_valid", 32'(valid_cnt - v0), 32'd0);
        check("order_hold",  32'(bus.value_out),  32'hBEEF);
        drive_frame(16'hA5C3, 8);
        check("order_recover", 32'(bus.value_out), 32'hA5C3);

        // Format error during the d3 dwell.
        v0 = valid_cnt;
        s0 = seq_cnt;
        f0 = fmt_cnt;
        drive_dwell(4'b1110, 7'h03, 8);
        drive_dwell(4'b0111, 7'h15, 8);
        drive_dwell(4'b1011, 7'h02, 8);
        drive_dwell(4'b1101, 7'h01, 8);
        check("fmt_pulse", 32'(fmt_cnt - f0),   32'd1);
        check("fmt_valid", 32'(valid_cnt - v0), 32'd0);
        check("fmt_seq",   32'(seq_cnt - s0),   32'd0);
        check("fmt_hold",  32'(bus.value_out),  32'hA5C3);

        // Timeout: freeze the anode at 0111 while capturing.
        v0 = valid_cnt;
        s0 = seq_cnt;
        drive_dwell(4'b1110, 7'h06, 8);
        bus.anode_in = 4'b0111;
        bus.digit_in = 7'h05;
        repeat (4090) @(negedge clk);
        check("timeout_early", 32'(bus.stale), 32'h0);
        repeat (10) @(negedge clk);
        check("timeout_stale", 32'(bus.stale), 32'h1);
        check("timeout_valid", 32'(valid_cnt - v0), 32'd0);
        check("timeout_seq",   32'(seq_cnt - s0),   32'd0);
        check("timeout_hold",  32'(bus.value_out),  32'hA5C3);
        drive_frame(16'h0F0F, 8);
        check("resume_stale", 32'(bus.stale), 32'h0);
        check("resume_value", 32'(bus.value_out), 32'h0F0F);

        // Reset pulse during the d2 dwell drops that frame.
        v0 = valid_cnt;
        drive_dwell(4'b1110, 7'h01, 8);
        drive_dwell(4'b0111, 7'h02, 8);
        drive_dwell(4'b1011, 7'h03, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drive_dwell(4'b1101, 7'h04, 8);
        check("midrst_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_value", 32'(bus.value_out), 32'h0);
        drive_frame(16'h1357, 8);
        check("midrst_recover", 32'(bus.value_out), 32'h1357);

        check("hold_only_on_valid", 32'(hold_bad),  32'd0);
        check("pulses_one_cycle",   32'(pulse_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
